// File: rtl/arbiter_puf_pkg.sv
// ---------------------------------------------------------------------------
// arbiter_puf_pkg
// Shared definitions for the arbiter PUF evaluation engine: default
// parameter values and the controller state type.
// ---------------------------------------------------------------------------
package arbiter_puf_pkg;

    localparam int DEF_C_LENGTH      = 8;  // mux stages per chain / challenge width
    localparam int DEF_N_CHAINS      = 8;  // external delay-chain + arbiter macros
    localparam int DEF_VOTES         = 7;  // excitations per challenge (odd)
    localparam int DEF_SETTLE_CYCLES = 2;  // settle time in clocks

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FIRE,
        ST_RELAX,
        ST_DONE
    } puf_state_e;

endpackage

// File: rtl/arbiter_puf_engine_if.sv
// ---------------------------------------------------------------------------
// arbiter_puf_engine_if
// Host-side request/response bundle of the PUF engine.
//   start, abort, challenge : host -> engine
//   busy, done              : engine status
//   response, stable        : per-chain voted result, valid from each done
// master = host, slave = engine.
// ---------------------------------------------------------------------------
interface arbiter_puf_engine_if
    import arbiter_puf_pkg::*;
#(
    parameter int C_LENGTH = DEF_C_LENGTH,
    parameter int N_CHAINS = DEF_N_CHAINS
);

    logic                start;
    logic                abort;
    logic [C_LENGTH-1:0] challenge;
    logic                busy;
    logic                done;
    logic [N_CHAINS-1:0] response;
    logic [N_CHAINS-1:0] stable;

    modport master (
        output start, abort, challenge,
        input  busy, done, response, stable
    );

    modport slave (
        input  start, abort, challenge,
        output busy, done, response, stable
    );

endinterface

// File: rtl/puf_vote_counter.sv
// ---------------------------------------------------------------------------
// puf_vote_counter
// One per delay chain. Brings the asynchronous arbiter output into the clk
// domain, counts how many excitations resolved to 1 and, on update, turns
// the count into a majority bit and an all-samples-agreed flag.
//   clk, rst_n : clock, async active-low reset
//   clear      : start of a new evaluation, zero the ones counter
//   sample_en  : last FIRE cycle, add the synchronised bit
//   update     : DONE cycle, refresh response/stable
//   arb_bit    : raw arbiter latch output (asynchronous)
//   response   : ones > VOTES/2
//   stable     : ones == 0 or ones == VOTES
// ---------------------------------------------------------------------------
module puf_vote_counter
    import arbiter_puf_pkg::*;
#(
    parameter int VOTES = DEF_VOTES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic sample_en,
    input  logic update,
    input  logic arb_bit,
    output logic response,
    output logic stable
);

    localparam int                CNT_W   = $clog2(VOTES + 1);
    localparam logic [CNT_W-1:0]  VOTES_C = CNT_W'(VOTES);
    localparam logic [CNT_W-1:0]  HALF_C  = CNT_W'(VOTES / 2);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] ones_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            ones_q   <= '0;
            response <= 1'b0;
            stable   <= 1'b0;
        end else begin
            // Two-flop synchroniser runs freely; only the sample taken on the
            // last FIRE cycle is counted, so the arbiter has settled by then.
            sync_q1 <= arb_bit;
            sync_q2 <= sync_q1;

            if (clear) begin
                ones_q <= '0;
            end else if (sample_en) begin
                ones_q <= ones_q + CNT_W'(sync_q2);
            end

            if (update) begin
                response <= (ones_q > HALF_C);
                stable   <= (ones_q == '0) || (ones_q == VOTES_C);
            end
        end
    end

endmodule

// File: rtl/arbiter_puf_engine.sv
// ---------------------------------------------------------------------------
// arbiter_puf_engine
// Sequencer for an arbiter PUF built from external delay chains. For each
// accepted challenge it fires the chains VOTES times and reports a
// majority-voted response bit and a stability flag per chain.
//
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   host        : arbiter_puf_engine_if.slave (start/abort/challenge in,
//                 busy/done/response/stable out)
//   chain_chal  : per-chain select bits, slice i = challenge rotl (i % C_LENGTH)
//   excite      : launch edge into all chains, straight from a flop
//   arb_resp    : arbiter outputs, asynchronous to clk
//
// Sequence: IDLE -> SETUP (S) -> { FIRE (S+2) -> RELAX (S) } x VOTES -> DONE.
// The DONE state lasts one cycle; the edge leaving it raises done and
// updates response/stable while busy falls, so done appears
// S + VOTES*(2S+2) + 1 cycles after the acceptance edge. abort in any
// non-IDLE state returns to IDLE with no done and results untouched.
// VOTES must be odd and >= 1, SETTLE_CYCLES >= 1.
// ---------------------------------------------------------------------------
module arbiter_puf_engine
    import arbiter_puf_pkg::*;
#(
    parameter int C_LENGTH      = DEF_C_LENGTH,
    parameter int N_CHAINS      = DEF_N_CHAINS,
    parameter int VOTES         = DEF_VOTES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    arbiter_puf_engine_if.slave          host,
    output logic [N_CHAINS*C_LENGTH-1:0] chain_chal,
    output logic                         excite,
    input  logic [N_CHAINS-1:0]          arb_resp
);

    localparam int                CNT_W      = $clog2(VOTES + 1);
    localparam int                PHASE_W    = $clog2(SETTLE_CYCLES + 3);
    localparam logic [PHASE_W-1:0] SETTLE_LAST = PHASE_W'(SETTLE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] FIRE_LAST   = PHASE_W'(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   VOTES_C     = CNT_W'(VOTES);

    puf_state_e          state_q;
    logic [PHASE_W-1:0]  phase_q;   // cycles spent in the current state
    logic [CNT_W-1:0]    vote_q;    // completed excitations
    logic [CNT_W-1:0]    vote_next;
    logic [C_LENGTH-1:0] chal_q;
    logic                excite_q;
    logic                busy_q;
    logic                done_q;
    logic                abort_act;
    logic                accept;
    logic                sample_en;
    logic                update;

    assign abort_act = host.abort && (state_q != ST_IDLE);
    assign accept    = host.start && (state_q == ST_IDLE);
    assign sample_en = (state_q == ST_FIRE) && (phase_q == FIRE_LAST) && !abort_act;
    assign update    = (state_q == ST_DONE) && !abort_act;
    assign vote_next = vote_q + CNT_W'(1);

    // NOTE: every register here is assigned with <= so all flops see the
    // pre-edge values of each other; blocking assignments would make the
    // result depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            vote_q   <= '0;
            chal_q   <= '0;
            excite_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_act) begin
                state_q  <= ST_IDLE;
                phase_q  <= '0;
                excite_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            chal_q  <= host.challenge;
                            vote_q  <= '0;
                            phase_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        if (phase_q == SETTLE_LAST) begin
                            phase_q  <= '0;
                            excite_q <= 1'b1;
                            state_q  <= ST_FIRE;
                        end else begin
                            phase_q <= phase_q + PHASE_W'(1);
                        end
                    end
                    ST_FIRE: begin
                        if (phase_q == FIRE_LAST) begin
                            phase_q  <= '0;
                            excite_q <= 1'b0;
                            state_q  <= ST_RELAX;
                        end else begin
                            phase_q <= phase_q + PHASE_W'(1);
                        end
                    end
                    ST_RELAX: begin
                        if (phase_q == SETTLE_LAST) begin
                            phase_q <= '0;
                            vote_q  <= vote_next;
                            if (vote_next == VOTES_C) begin
                                state_q <= ST_DONE;
                            end else begin
                                excite_q <= 1'b1;
                                state_q  <= ST_FIRE;
                            end
                        end else begin
                            phase_q <= phase_q + PHASE_W'(1);
                        end
                    end
                    ST_DONE: begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign excite    = excite_q;
    assign host.busy = busy_q;
    assign host.done = done_q;

    // Each chain sees the challenge rotated by its index so chains sharing a
    // challenge still exercise different select patterns. Pure wiring.
    for (genvar gi = 0; gi < N_CHAINS; gi++) begin : g_chal
        for (genvar gj = 0; gj < C_LENGTH; gj++) begin : g_bit
            assign chain_chal[gi*C_LENGTH + gj] =
                chal_q[(gj + C_LENGTH - (gi % C_LENGTH)) % C_LENGTH];
        end
    end

    // NOTE: response/stable live in reset flops inside each counter; they are
    // only written on update, so they hold across idle periods and aborts.
    for (genvar gi = 0; gi < N_CHAINS; gi++) begin : g_vote
        puf_vote_counter #(
            .VOTES (VOTES)
        ) u_vote (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (accept),
            .sample_en (sample_en),
            .update    (update),
            .arb_bit   (arb_resp[gi]),
            .response  (host.response[gi]),
            .stable    (host.stable[gi])
        );
    end

endmodule

// File: tb/tb_arbiter_puf_engine.sv
// ---------------------------------------------------------------------------
// tb_arbiter_puf_engine
// Self-checking bench: a cycle-offset reference model of one evaluation is
// compared against the default-parameter engine on every falling edge, and
// literal expectations pin the model for the documented scenarios. A second
// engine with VOTES=1, SETTLE_CYCLES=1 covers the minimal configuration.
// ---------------------------------------------------------------------------
module tb_arbiter_puf_engine;

    localparam int C = 8;
    localparam int N = 8;
    localparam int V = 7;
    localparam int S = 2;
    localparam int P = 2 * S + 2;       // cycles per excitation (FIRE + RELAX)
    localparam int T = S + V * P + 1;   // acceptance edge -> done

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arbiter_puf_engine_if #(.C_LENGTH(C), .N_CHAINS(N)) hif ();
    logic [N*C-1:0] chain_chal;
    logic           excite;
    logic [N-1:0]   arb_resp;

    arbiter_puf_engine #(
        .C_LENGTH(C), .N_CHAINS(N), .VOTES(V), .SETTLE_CYCLES(S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host       (hif),
        .chain_chal (chain_chal),
        .excite     (excite),
        .arb_resp   (arb_resp)
    );

    arbiter_puf_engine_if #(.C_LENGTH(C), .N_CHAINS(N)) sif ();
    logic [N*C-1:0] s_chain_chal;
    logic           s_excite;
    logic [N-1:0]   s_arb;

    arbiter_puf_engine #(
        .C_LENGTH(C), .N_CHAINS(N), .VOTES(1), .SETTLE_CYCLES(1)
    ) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .host       (sif),
        .chain_chal (s_chain_chal),
        .excite     (s_excite),
        .arb_resp   (s_arb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [N*C-1:0] exp_chain(input logic [C-1:0] x);
        logic [N*C-1:0] r;
        logic [2*C-1:0] t;
        r = '0;
        for (int i = 0; i < N; i++) begin
            t = {x, x} << (i % C);
            r[i*C +: C] = t[2*C-1 -: C];
        end
        return r;
    endfunction

    function automatic bit is_sample(input int k);
        int d;
        d = k - 2 * S;
        return (d >= 0) && (d % P == 0) && (d / P < V);
    endfunction

    function automatic bit exp_excite(input int k);
        return (k >= S) && (k < S + V * P) && ((k - S) % P < S + 2);
    endfunction

    int         m_k;
    bit         m_active;
    bit         m_done;
    logic [C-1:0] m_chal;
    logic [N-1:0] m_resp;
    logic [N-1:0] m_stable;
    int         m_ones [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_done   <= 1'b0;
            m_chal   <= '0;
            m_resp   <= '0;
            m_stable <= '0;
            for (int i = 0; i < N; i++) m_ones[i] <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (hif.abort) begin
                    m_active <= 1'b0;
                end else begin
                    m_k <= m_k + 1;
                    if (is_sample(m_k + 1))
                        for (int i = 0; i < N; i++) m_ones[i] <= m_ones[i] + int'(arb_resp[i]);
                    if (m_k + 1 == T) begin
                        m_active <= 1'b0;
                        m_done   <= 1'b1;
                        for (int i = 0; i < N; i++) begin
                            m_resp[i]   <= (2 * m_ones[i] > V);
                            m_stable[i] <= (m_ones[i] == 0) || (m_ones[i] == V);
                        end
                    end
                end
            end else if (hif.start) begin
                m_active <= 1'b1;
                m_k      <= 0;
                m_chal   <= hif.challenge;
                for (int i = 0; i < N; i++) m_ones[i] <= 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy",       {63'd0, hif.busy}, {63'd0, m_active});
            check("excite",     {63'd0, excite},   {63'd0, m_active && exp_excite(m_k)});
            check("done",       {63'd0, hif.done}, {63'd0, m_done});
            check("response",   64'(hif.response), 64'(m_resp));
            check("stable",     64'(hif.stable),   64'(m_stable));
            check("chain_chal", chain_chal,        exp_chain(m_chal));
        end
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] vote_pat [V];

    // Hold the vote's pattern from the start of its FIRE window through its
    // sample edge; elsewhere optionally scramble the arbiter outputs.
    task automatic drive_arb(input int k, input bit noise);
        if (noise) arb_resp = N'($urandom);
        for (int v = 0; v < V; v++)
            if (k >= S + v * P && k < 2 * S + v * P) arb_resp = vote_pat[v];
    endtask

    task automatic run_eval(input logic [C-1:0] chal, input bit noise, input int abort_k,
                            input int restart_k, input int rst_k, output int done_k);
        int k;
        done_k = -1;
        @(posedge clk); #1;
        hif.start = 1'b1;
        hif.challenge = chal;
        @(posedge clk); #1;
        hif.start = 1'b0;
        hif.challenge = C'($urandom);
        k = 0;
        drive_arb(k, noise);
        while (k < T + 2) begin
            @(posedge clk); #1;
            k++;
            if (hif.done && done_k < 0) done_k = k;
            if (k == abort_k + 1) begin
                check("abort_excite", {63'd0, excite},   64'd0);
                check("abort_busy",   {63'd0, hif.busy}, 64'd0);
            end
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                check("rst_excite",   {63'd0, excite},   64'd0);
                check("rst_busy",     {63'd0, hif.busy}, 64'd0);
                check("rst_response", 64'(hif.response), 64'd0);
                check("rst_stable",   64'(hif.stable),   64'd0);
                check("rst_chal",     chain_chal,        64'd0);
                #1;
                rst_n = 1'b1;
                break;
            end
            hif.abort = (k == abort_k);
            hif.start = (k == restart_k);
            if (k == restart_k) hif.challenge = ~chal;
            drive_arb(k, noise);
        end
        hif.abort = 1'b0;
        hif.start = 1'b0;
    endtask

    int           done_k;
    int           n;
    logic [N-1:0] prev_resp;
    logic [C-1:0] chal;

    initial begin
        hif.start = 1'b0; hif.abort = 1'b0; hif.challenge = '0;
        sif.start = 1'b0; sif.abort = 1'b0; sif.challenge = '0;
        arb_resp = '0;
        s_arb = '1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        check("reset_busy",     {63'd0, hif.busy}, 64'd0);
        check("reset_excite",   {63'd0, excite},   64'd0);
        check("reset_done",     {63'd0, hif.done}, 64'd0);
        check("reset_response", 64'(hif.response), 64'd0);
        check("reset_stable",   64'(hif.stable),   64'd0);
        check("reset_chal",     chain_chal,        64'd0);
        #11 rst_n = 1'b1;

        // Constant arbiter outputs: response mirrors them, all chains stable.
        arb_resp = 8'h3C;
        for (int v = 0; v < V; v++) vote_pat[v] = 8'h3C;
        run_eval(8'hA5, 1'b0, -10, -10, -10, done_k);
        check("const_done_cycle", 64'(done_k), 64'd45);
        check("const_response",   64'(hif.response), 64'h3C);
        check("const_stable",     64'(hif.stable),   64'hFF);
        check("const_slice1",     64'(chain_chal[15:8]), 64'h4B);

        // Chain 0 high on 4 of 7 samples, chain 1 on 3 of 7.
        for (int v = 0; v < V; v++) begin
            vote_pat[v] = N'($urandom);
            vote_pat[v][0] = (v < 4);
            vote_pat[v][1] = (v < 3);
        end
        run_eval(C'($urandom), 1'b1, -10, -10, -10, done_k);
        check("vote_done_cycle", 64'(done_k), 64'd45);
        check("vote_response",   64'(hif.response[1:0]), 64'd1);
        check("vote_stable",     64'(hif.stable[1:0]),   64'd0);

        // Abort during the third FIRE window: no done, results untouched.
        prev_resp = m_resp;
        for (int v = 0; v < V; v++) vote_pat[v] = ~vote_pat[v];
        run_eval(C'($urandom), 1'b1, S + 2 * P + 1, -10, -10, done_k);
        check("abort_no_done",  64'(done_k), 64'hFFFF_FFFF_FFFF_FFFF);
        check("abort_response", 64'(hif.response), 64'(prev_resp));

        // Start pulsed mid-evaluation is ignored.
        for (int v = 0; v < V; v++) vote_pat[v] = N'($urandom);
        chal = 8'h3E;
        run_eval(chal, 1'b1, -10, 11, -10, done_k);
        check("restart_done_cycle", 64'(done_k), 64'd45);
        check("restart_slice0",     64'(chain_chal[7:0]), 64'h3E);

        // Randomised evaluations.
        for (int r = 0; r < 4; r++) begin
            for (int v = 0; v < V; v++) vote_pat[v] = N'($urandom);
            run_eval(C'($urandom), 1'b1, -10, -10, -10, done_k);
            check("rand_done_cycle", 64'(done_k), 64'd45);
        end

        // Reset during RELAX of the second excitation, then a normal run.
        run_eval(C'($urandom), 1'b1, -10, -10, S + P + S + 2, done_k);
        for (int v = 0; v < V; v++) vote_pat[v] = N'($urandom);
        run_eval(8'h5A, 1'b1, -10, -10, -10, done_k);
        check("post_rst_done_cycle", 64'(done_k), 64'd45);

        // Minimal configuration: VOTES=1, SETTLE_CYCLES=1.
        @(posedge clk); #1;
        sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
        n = 0;
        while (n < 20 && !sif.done) begin
            @(posedge clk); #1;
            n++;
        end
        check("small_done_cycle", 64'(n), 64'd6);
        check("small_response",   64'(sif.response), 64'hFF);
        check("small_stable",     64'(sif.stable),   64'hFF);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arbiter_puf_engine.md
ARBITER_PUF_ENGINE -- requirements
Module: arbiter_puf_engine

Interface
REQ-001 SHALL have parameter C_LENGTH, default 8: mux stages per chain and challenge width.
REQ-002 SHALL have parameter N_CHAINS, default 8: number of external delay-chain/arbiter macros.
REQ-003 SHALL have parameter VOTES, default 7: excitations per challenge; odd, >=1.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 2: settle time in clocks; >=1.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  in  1  request evaluation of challenge.
REQ-008 SHALL have port abort  in  1  synchronous cancel of an evaluation in progress.
REQ-009 SHALL have port challenge  in  C_LENGTH  challenge, sampled when start is accepted.
REQ-010 SHALL have port chain_chal  out  N_CHAINS*C_LENGTH  per-chain select bits; slice i = latched challenge rotated left by (i mod C_LENGTH).
REQ-011 SHALL have port excite  out  1  launch edge driven into all chains.
REQ-012 SHALL have port arb_resp  in  N_CHAINS  arbiter latch outputs, asynchronous to clk.
REQ-013 SHALL have port busy  out  1  high from acceptance until the DONE cycle inclusive.
REQ-014 SHALL have port done  out  1  one-cycle pulse: response/stable updated.
REQ-015 SHALL have port response  out  N_CHAINS  majority-voted response bit per chain.
REQ-016 SHALL have port stable  out  N_CHAINS  1 when all VOTES samples of that chain agreed.

Function
REQ-017 SHALL implement FSM IDLE -> SETUP -> FIRE -> RELAX -> (FIRE | DONE) -> IDLE.
REQ-018 SHALL accept start only in IDLE: latch challenge, clear vote counters and per-chain ones counters, enter SETUP; start outside IDLE ignored.
REQ-019 SETUP: excite=0 for SETTLE_CYCLES cycles, then FIRE.
REQ-020 FIRE: excite=1 for SETTLE_CYCLES+2 cycles; arb_resp passes a 2-flop synchroniser; on last FIRE cycle each chain's ones counter increments by its synchronised bit.
REQ-021 RELAX: excite=0 for SETTLE_CYCLES cycles; vote count increments; if count == VOTES -> DONE, else FIRE.
REQ-022 DONE: one cycle; response[i] = (ones[i] > VOTES/2); stable[i] = (ones[i]==0 or ones[i]==VOTES); done=1; then IDLE.
REQ-023 done SHALL assert exactly SETTLE_CYCLES + VOTES*(2*SETTLE_CYCLES+2) + 1 cycles after the start-acceptance edge.
REQ-024 response and stable SHALL hold their values until the next DONE; unchanged by abort.
REQ-025 chain_chal SHALL hold the latched challenge constant for the whole evaluation and after it until the next acceptance.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE next cycle with excite=0, busy=0, no done; abort in IDLE has no effect; abort has priority over start and state progression.
REQ-027 Counter widths SHALL be clog2(VOTES+1) (ones) and clog2(VOTES+1) (votes); no wrap reachable.
REQ-028 excite SHALL come directly from a flop (glitch-free).

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, excite=0, busy=0, done=0, response=0, stable=0, chain_chal=0, all counters and synchroniser flops 0.
REQ-030 Reset asserted mid-evaluation SHALL discard the evaluation; first start after release is accepted normally.

Structure
REQ-031 Package arbiter_puf_pkg SHALL hold the FSM state typedef and default parameter constants.
REQ-032 Sub-module puf_vote_counter SHALL be instantiated once per chain (synchroniser, ones counter, majority/stable compare).
REQ-033 Delay chains and arbiters SHALL stay outside this module.

Verification
REQ-034 Defaults, challenge=8'hA5, arb_resp=8'h3C constant -> done 45 cycles after acceptance, response=8'h3C, stable=8'hFF; chain_chal slice1=8'h4B.
REQ-035 arb_resp bit0 high on 4 of 7 FIRE samples, bit1 high on 3 -> response[1:0]=2'b01, stable[1:0]=2'b00.
REQ-036 abort during third FIRE -> excite=0 and busy=0 next cycle, no done, response unchanged from prior run.
REQ-037 start pulsed while busy -> ignored, single done at cycle 45, challenge from first start used.
REQ-038 rst_n low during RELAX -> excite, busy, response, stable all 0 immediately; subsequent start completes normally.
REQ-039 VOTES=1, SETTLE_CYCLES=1, arb_resp=all 1 -> done at cycle 6, response=all 1, stable=all 1.
